// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues imem reads at PC, drives the PC advance enable,
// and owns the IF/ID pipeline latch (instr, pc, pc+4, valid).
module if_fetch_stage #(
    parameter logic [5:0]  HALT_OP   = 6'b111111,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] PC,
    input  logic        flush,
    input  logic        halt,
    input  logic        id_stall,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        pc_adv,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;

    // State register, drain address and IF/ID latch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            drain_addr_q <= 32'h0000_0000;
            valid_q      <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_q         <= 32'h0000_0000;
            npc_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
        end
    end

    // Next-state, latch update and memory/PC-control outputs
    always_comb begin
        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        imemREN      = 1'b1;
        imemaddr     = PC;
        pc_adv       = 1'b0;

        case (state_q)
            FETCH: begin
                if (halt) begin
                    if (!id_stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end else begin
                        valid_d = valid_q;
                    end
                    state_d = HALTED;
                end else if (flush) begin
                    // Flush overrides stall; a miss leaves a stale request in flight.
                    pc_adv  = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (!ihit) begin
                        drain_addr_d = PC;
                        state_d      = DRAIN;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (id_stall) begin
                    valid_d = valid_q;
                end else if (ihit) begin
                    pc_adv  = 1'b1;
                    valid_d = 1'b1;
                    instr_d = iload;
                    pc_d    = PC;
                    npc_d   = PC + 32'd4;
                    if (iload[31:26] == HALT_OP) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end

            DRAIN: begin
                // Hold the stale address until memory answers it.
                imemaddr = drain_addr_q;
                if (halt) begin
                    if (!id_stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end else begin
                        valid_d = valid_q;
                    end
                    state_d = HALTED;
                end else if (flush) begin
                    pc_adv  = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    if (!id_stall) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end else begin
                        valid_d = valid_q;
                    end
                    if (ihit) begin
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            HALTED: begin
                imemREN = 1'b0;
                if (!id_stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else begin
                    valid_d = valid_q;
                end
            end

            default: begin
                state_d = FETCH;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        endcase
    end

    assign ifid_valid = valid_q;
    assign ifid_instr = instr_q;
    assign ifid_pc    = pc_q;
    assign ifid_npc   = npc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a directed vector table, hand-written reset/drain
// sequences, and randomized traffic against a rule-level reference model.
module tb_if_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic [31:0] PC;
    logic        flush;
    logic        halt;
    logic        id_stall;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pc_adv;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .PC(PC), .flush(flush), .halt(halt),
        .id_stall(id_stall), .ihit(ihit), .iload(iload),
        .imemREN(imemREN), .imemaddr(imemaddr), .pc_adv(pc_adv),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_npc(ifid_npc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic h, input logic f, input logic s, input logic ih,
                          input logic [31:0] pc, input logic [31:0] ld);
        halt = h; flush = f; id_stall = s; ihit = ih; PC = pc; iload = ld;
        #1;
    endtask

    // ---------------- reference model ----------------
    bit          m_halted;
    bit          m_drain;
    logic [31:0] m_daddr;
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_npc;

    task automatic model_reset();
        m_halted = 1'b0; m_drain = 1'b0; m_daddr = 32'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0; m_npc = 32'h0;
    endtask

    task automatic model_check_comb();
        logic        e_ren, e_adv;
        logic [31:0] e_addr;
        e_ren  = !m_halted;
        e_addr = (m_drain && !m_halted) ? m_daddr : PC;
        e_adv  = !m_halted && !halt && (flush || (!m_drain && !id_stall && ihit));
        chk("rnd_imemREN", {31'b0, imemREN}, {31'b0, e_ren});
        chk("rnd_imemaddr", imemaddr, e_addr);
        chk("rnd_pc_adv", {31'b0, pc_adv}, {31'b0, e_adv});
    endtask

    task automatic model_clock();
        bit live_flush, hold, capture;
        live_flush = flush && !halt && !m_halted;
        hold    = id_stall && !live_flush;
        capture = !hold && !m_halted && !m_drain && !halt && !flush && ihit;
        if (capture) begin
            m_valid = 1'b1; m_instr = iload; m_pc = PC; m_npc = PC + 32'd4;
        end else if (!hold) begin
            m_valid = 1'b0; m_instr = 32'h0;
        end
        if (m_halted) begin
            m_halted = 1'b1;
        end else if (halt || (capture && iload[31:26] == 6'b111111)) begin
            m_halted = 1'b1;
        end else if (m_drain) begin
            if (!flush && ihit) m_drain = 1'b0;
        end else if (flush && !ihit) begin
            m_drain = 1'b1;
            m_daddr = PC;
        end
    endtask

    task automatic model_check_latch();
        chk("rnd_ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        chk("rnd_ifid_instr", ifid_instr, m_instr);
        chk("rnd_ifid_pc", ifid_pc, m_pc);
        chk("rnd_ifid_npc", ifid_npc, m_npc);
    endtask

    // Async reset applied mid-cycle; checks the immediate effect.
    task automatic do_reset();
        nRST = 1'b0;
        #1;
        model_reset();
        chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_npc", ifid_npc, 32'h0);
        chk("rst_imemREN", {31'b0, imemREN}, 32'h1);
        chk("rst_imemaddr", imemaddr, PC);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        h, f, s, ih;
        logic [31:0] pc, ld;
        logic        e_ren, e_adv;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc, e_npc;
    } vec_t;

    vec_t vt[16];

    initial begin
        nRST = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        //        h     f     s     ih    pc            iload         ren   adv   addr          v     instr         pc            npc
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h2008_0005, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h2008_0005, 32'h0000_0040, 32'h0000_0044};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0040, 32'h0000_0044};
        vt[2]  = vt[1];
        vt[3]  = vt[1];
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h1111_1111, 32'h0000_0100, 32'h0000_0104};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h2222_2222, 1'b1, 1'b0, 32'h0000_0104, 1'b1, 32'h1111_1111, 32'h0000_0100, 32'h0000_0104};
        vt[6]  = vt[5];
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h2222_2222, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h2222_2222, 32'h0000_0104, 32'h0000_0108};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0104, 32'h0000_0108};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0104, 32'h0000_0108};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'h0000_0104, 32'h0000_0108};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h3333_3333, 32'h0000_0080, 32'h0000_0084};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h4444_4444, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4444_4444, 32'hFFFF_FFFC, 32'h0000_0000};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'hFC00_0000, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'hFC00_0000, 32'h0000_0020, 32'h0000_0024};
        vt[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0024, 32'h5555_5555, 1'b0, 1'b0, 32'h0000_0024, 1'b0, 32'h0000_0000, 32'h0000_0020, 32'h0000_0024};
        vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0024, 1'b0, 32'h0000_0000, 32'h0000_0020, 32'h0000_0024};

        @(negedge CLK);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            set_in(vt[i].h, vt[i].f, vt[i].s, vt[i].ih, vt[i].pc, vt[i].ld);
            chk($sformatf("vec%0d_imemREN", i), {31'b0, imemREN}, {31'b0, vt[i].e_ren});
            chk($sformatf("vec%0d_imemaddr", i), imemaddr, vt[i].e_addr);
            chk($sformatf("vec%0d_pc_adv", i), {31'b0, pc_adv}, {31'b0, vt[i].e_adv});
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vt[i].e_valid});
            chk($sformatf("vec%0d_ifid_instr", i), ifid_instr, vt[i].e_instr);
            chk($sformatf("vec%0d_ifid_pc", i), ifid_pc, vt[i].e_pc);
            chk($sformatf("vec%0d_ifid_npc", i), ifid_npc, vt[i].e_npc);
            @(negedge CLK);
        end

        // Reset while in DRAIN: stale address must be forgotten immediately.
        do_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h5555_5555);
        @(posedge CLK); #1;
        chk("seq_hit_valid", {31'b0, ifid_valid}, 32'h1);
        @(negedge CLK);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0000);
        @(posedge CLK); #1;
        chk("seq_flush_valid", {31'b0, ifid_valid}, 32'h0);
        @(negedge CLK);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_0000);
        chk("seq_drain_addr", imemaddr, 32'h0000_0300);
        do_reset();
        chk("seq_post_rst_addr", imemaddr, 32'h0000_0400);

        // Halt outranks flush and stall: latch holds, no advance.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h6666_6666);
        @(posedge CLK); #1;
        @(negedge CLK);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0504, 32'h7777_7777);
        chk("seq_halt_adv", {31'b0, pc_adv}, 32'h0);
        @(posedge CLK); #1;
        chk("seq_halt_hold_instr", ifid_instr, 32'h6666_6666);
        chk("seq_halt_hold_valid", {31'b0, ifid_valid}, 32'h1);
        @(negedge CLK);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0504, 32'h7777_7777);
        chk("seq_halted_ren", {31'b0, imemREN}, 32'h0);
        @(posedge CLK); #1;
        chk("seq_halted_bubble", {31'b0, ifid_valid}, 32'h0);
        @(negedge CLK);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ld;
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end
            ld = $urandom();
            if ($urandom_range(0, 15) == 0) ld[31:26] = 6'b111111;
            set_in($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                   {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ld);
            model_check_comb();
            @(posedge CLK);
            model_clock();
            #1;
            model_check_latch();
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage between the PC register and the decode stage. It issues instruction-memory reads at the current PC and drives the PC register's advance enable. It also owns the IF/ID pipeline latch: instruction, PC, PC+4 and valid. It handles decode back-pressure, branch/jump flushes (including a flush that lands while a miss is outstanding) and halt.

Parameters:
HALT_OP, 6'b111111, opcode field value (instr[31:26]) that identifies a HALT instruction
NOP_INSTR, 32'h0000_0000, instruction value loaded into the latch on bubbles and reset

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
PC  in  32  current PC from PC register
flush  in  1  redirect from downstream (branch/jump resolved); PC register loads target this cycle when pc_adv=1
halt  in  1  external halt (pipeline drained / fault), level
id_stall  in  1  decode cannot accept a new IF/ID entry this cycle
ihit  in  1  instruction memory returns data for imemaddr this cycle
iload  in  32  instruction data, valid when ihit=1
imemREN  out  1  instruction read enable
imemaddr  out  32  instruction read address
pc_adv  out  1  advance enable to PC register (Adv)
ifid_valid  out  1  IF/ID entry valid
ifid_instr  out  32  latched instruction
ifid_pc  out  32  PC of latched instruction
ifid_npc  out  32  ifid_pc + 4

Behaviour:
- Reset (nRST=0, async):
  - state=FETCH; drain_addr=0.
  - ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_npc=0.
- Outputs imemREN, imemaddr and pc_adv are combinational from state and inputs.
- IF/ID latch updates on CLK rising edge only.
- Bubble = ifid_valid<=0, ifid_instr<=NOP_INSTR; ifid_pc and ifid_npc hold.
- Hold = all IF/ID fields unchanged.
- Priority within a cycle: halt > flush > id_stall > ihit.
- States: FETCH, DRAIN, HALTED.
- FETCH: imemREN=1, imemaddr=PC.
  - halt=1: pc_adv=0; latch holds if id_stall, else bubble; next HALTED.
  - flush=1: pc_adv=1; latch bubble regardless of id_stall (flush overrides stall).
    - If ihit=0: drain_addr<=PC, next DRAIN.
    - If ihit=1: fetched data discarded, stay FETCH.
  - id_stall=1: pc_adv=0; latch holds; stay FETCH. ihit data this cycle is dropped; the same PC is re-requested.
  - ihit=1: pc_adv=1; ifid_valid<=1, ifid_instr<=iload, ifid_pc<=PC, ifid_npc<=PC+4.
    - PC+4 is 32-bit modulo: 32'hFFFF_FFFC -> 32'h0000_0000.
    - If iload[31:26]==HALT_OP: next HALTED (the HALT itself is delivered valid). Otherwise stay FETCH.
  - ihit=0: pc_adv=0; latch bubble; stay FETCH.
- DRAIN (stale request outstanding; memory must not see an address change mid-miss):
  - imemREN=1, imemaddr=drain_addr.
  - halt=1: pc_adv=0; latch rules as FETCH halt; next HALTED.
  - flush=1: pc_adv=1; latch bubble; stay DRAIN; drain_addr unchanged.
  - Otherwise: pc_adv=0. Latch holds if id_stall, else bubble.
  - ihit=1: data discarded, next FETCH. Otherwise stay DRAIN.
- HALTED:
  - imemREN=0, imemaddr=PC, pc_adv=0.
  - Latch holds if id_stall, else bubble (the delivered HALT drains once).
  - Terminal until reset. flush and ihit are ignored.
- Invariants:
  - pc_adv=1 only in FETCH with a consumed hit, or on flush in FETCH/DRAIN.
  - imemaddr is stable for the whole DRAIN residency.
- Reset mid-operation (including in DRAIN or HALTED): immediate return to FETCH with reset values; no pending request is remembered.

Test Plan:
- Reset, PC=0x40, ihit=1 every cycle, iload=0x2008_0005, stall/flush/halt=0 -> imemREN=1, imemaddr=0x40, pc_adv=1; next edge ifid_valid=1, ifid_instr=0x2008_0005, ifid_pc=0x40, ifid_npc=0x44.
- PC=0x100, ihit=0 for 3 cycles then 1 -> pc_adv=0 and ifid_valid=0 for 3 cycles; 4th cycle pc_adv=1, latch gets pc 0x100.
- Valid entry latched, id_stall=1 for 2 cycles with ihit=1 -> pc_adv=0, IF/ID unchanged both cycles; stall released -> new entry captured.
- FETCH, PC=0x200, ihit=0, flush=1 -> pc_adv=1, state DRAIN, ifid_valid=0. Next cycle PC=0x80: imemaddr=0x200 until ihit; then imemaddr=0x80 and fetch resumes at 0x80; 0x200 data never appears in the latch.
- iload=0xFC00_0000 hit at PC=0x20 -> entry valid with instr 0xFC00_0000. Following cycles: imemREN=0, pc_adv=0, ifid_valid=0, even with flush=1.
- PC=0xFFFF_FFFC hit -> ifid_npc=0x0000_0000. Assert nRST=0 while in DRAIN -> immediate FETCH, ifid_valid=0, ifid_instr=NOP_INSTR.
